riscboy_ppu_busarb: RTL and testbench

// - Shares the PPU's single halfword read port between N_REQ address-phase requesters: pixel AGU, tilemap fetcher, command fetcher.
// - Arbitrates address phases onto one downstream bus.
// - Records which requester owns each issued fetch in an in-order tag FIFO.
// - Steers every returning data beat to its owner.
// - Sits between the PPU fetch agents and the PPU bus master adapter.

---
 rtl/riscboy_ppu_busarb_pkg.sv | 14 +
 rtl/riscboy_ppu_busarb_fifo.sv | 73 +++++++
 rtl/riscboy_ppu_busarb.sv | 155 +++++++++++++++
 tb/tb_riscboy_ppu_busarb.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/riscboy_ppu_busarb_pkg.sv
// Shared constants for the PPU bus arbiter: requester indices, tag width and lock states.
package riscboy_ppu_busarb_pkg;

    localparam int unsigned PPU_BUSARB_REQ_CMD     = 0;
    localparam int unsigned PPU_BUSARB_REQ_TILEMAP = 1;
    localparam int unsigned PPU_BUSARB_REQ_PIXEL   = 2;

    localparam int unsigned N_BUSARB_REQ = 3;
    localparam int unsigned W_BUSARB_TAG = $clog2(N_BUSARB_REQ);

    localparam logic LOCK_UNLOCKED = 1'b0;
    localparam logic LOCK_LOCKED   = 1'b1;

endpackage

// File: rtl/riscboy_ppu_busarb_fifo.sv
// In-order tag FIFO for the bus arbiter; pointers wrap modulo DEPTH (need not be a power of 2).
module riscboy_ppu_busarb_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned W_PTR   = $clog2(DEPTH);
    localparam int unsigned W_LEVEL = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [W_PTR-1:0]   wptr_q, wptr_d;
    logic [W_PTR-1:0]   rptr_q, rptr_d;
    logic [W_LEVEL-1:0] level_q, level_d;
    logic               do_push, do_pop;

    assign full_o  = (level_q == W_LEVEL'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            level_d = '0;
        end else begin
            if (do_push) begin
                wptr_d = (wptr_q == W_PTR'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            end
            if (do_pop) begin
                rptr_d = (rptr_q == W_PTR'(DEPTH - 1)) ? '0 : rptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/riscboy_ppu_busarb.sv
// PPU read-port arbiter: grants one requester's address phase and steers returning beats by tag.
// Define RISCBOY_PPU_BUSARB_RR_EN for round-robin arbitration; default is fixed priority.
module riscboy_ppu_busarb
    import riscboy_ppu_busarb_pkg::*;
#(
    parameter int unsigned N_REQ         = 3,
    parameter int unsigned W_ADDR        = 18,
    parameter int unsigned W_DATA        = 16,
    parameter int unsigned MAX_IN_FLIGHT = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_vld_i,
    output logic [N_REQ-1:0]        req_rdy_o,
    input  logic [N_REQ*W_ADDR-1:0] req_addr_i,
    output logic [N_REQ-1:0]        rsp_vld_o,
    output logic [W_DATA-1:0]       rsp_data_o,
    output logic                    bus_addr_vld_o,
    input  logic                    bus_addr_rdy_i,
    output logic [W_ADDR-1:0]       bus_addr_o,
    input  logic                    bus_data_vld_i,
    input  logic [W_DATA-1:0]       bus_data_i
);

    localparam int unsigned W_TAG = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [W_ADDR-1:0] req_addr_arr [N_REQ];
    logic              lock_q, lock_d;
    logic [W_TAG-1:0]  lock_gnt_q, lock_gnt_d;
    logic [W_TAG-1:0]  arb_gnt, gnt;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [W_TAG-1:0]  fifo_head;

    for (genvar i = 0; i < N_REQ; i++) begin : g_addr_unpack
        assign req_addr_arr[i] = req_addr_i[i*W_ADDR +: W_ADDR];
    end

`ifdef RISCBOY_PPU_BUSARB_RR_EN
    logic [W_TAG-1:0] rr_ptr_q, rr_ptr_d;
    logic [W_TAG:0]   rr_idx;
    logic             rr_found;

    // Search starts at rr_ptr and wraps; first valid requester found wins.
    always_comb begin
        arb_gnt  = rr_ptr_q;
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            rr_idx = {1'b0, rr_ptr_q} + (W_TAG + 1)'(k);
            if (rr_idx >= (W_TAG + 1)'(N_REQ)) begin
                rr_idx = rr_idx - (W_TAG + 1)'(N_REQ);
            end
            if (!rr_found && req_vld_i[rr_idx[W_TAG-1:0]]) begin
                arb_gnt  = rr_idx[W_TAG-1:0];
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (fifo_push) begin
            rr_ptr_d = (gnt == W_TAG'(N_REQ - 1)) ? '0 : gnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        arb_gnt = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (req_vld_i[W_TAG'(k)]) begin
                arb_gnt = W_TAG'(k);
            end
        end
    end
`endif

    // A stalled address phase keeps its owner until accepted, overriding arbitration.
    assign gnt            = (lock_q == LOCK_LOCKED) ? lock_gnt_q : arb_gnt;
    assign bus_addr_vld_o = (|req_vld_i) & ~fifo_full;
    assign bus_addr_o     = bus_addr_vld_o ? req_addr_arr[gnt] : '0;
    assign fifo_push      = bus_addr_vld_o & bus_addr_rdy_i;
    assign fifo_pop       = bus_data_vld_i & ~fifo_empty;
    assign rsp_data_o     = bus_data_i;

    always_comb begin
        req_rdy_o = '0;
        rsp_vld_o = '0;
        if (fifo_push) begin
            req_rdy_o[gnt] = 1'b1;
        end
        if (fifo_pop) begin
            rsp_vld_o[fifo_head] = 1'b1;
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_gnt_d = lock_gnt_q;
        case (lock_q)
            LOCK_UNLOCKED: begin
                if (bus_addr_vld_o && !bus_addr_rdy_i) begin
                    lock_d     = LOCK_LOCKED;
                    lock_gnt_d = gnt;
                end
            end
            LOCK_LOCKED: begin
                if (fifo_push) begin
                    lock_d = LOCK_UNLOCKED;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q     <= LOCK_UNLOCKED;
            lock_gnt_q <= '0;
        end else begin
            lock_q     <= lock_d;
            lock_gnt_q <= lock_gnt_d;
        end
    end

    riscboy_ppu_busarb_fifo #(
        .DEPTH (MAX_IN_FLIGHT),
        .WIDTH (W_TAG)
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (1'b0),
        .push_i  (fifo_push),
        .wdata_i (gnt),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    for (genvar i = 0; i < N_REQ; i++) begin : g_hold_chk
        a_req_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (req_vld_i[i] && !req_rdy_o[i]) |=> (req_vld_i[i] && $stable(req_addr_arr[i])));
    end

    a_no_orphan_beat: assert property (@(posedge clk) disable iff (!rst_n)
        bus_data_vld_i |-> !fifo_empty);

endmodule

// File: tb/tb_riscboy_ppu_busarb.sv
// Scoreboard bench for riscboy_ppu_busarb; honours RISCBOY_PPU_BUSARB_RR_EN for grant order.
module tb_riscboy_ppu_busarb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_vld = '0;
    logic [2:0]  req_rdy;
    logic [53:0] req_addr;
    logic [2:0]  rsp_vld;
    logic [15:0] rsp_data;
    logic        bus_addr_vld;
    logic        bus_addr_rdy = 1'b0;
    logic [17:0] bus_addr;
    logic        bus_data_vld = 1'b0;
    logic [15:0] bus_data = '0;

    logic [17:0] addr_tb [3];
    logic [1:0]  exp_tag_q [$];
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    assign req_addr = {addr_tb[2], addr_tb[1], addr_tb[0]};

    riscboy_ppu_busarb #(
        .N_REQ         (3),
        .W_ADDR        (18),
        .W_DATA        (16),
        .MAX_IN_FLIGHT (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_vld_i      (req_vld),
        .req_rdy_o      (req_rdy),
        .req_addr_i     (req_addr),
        .rsp_vld_o      (rsp_vld),
        .rsp_data_o     (rsp_data),
        .bus_addr_vld_o (bus_addr_vld),
        .bus_addr_rdy_i (bus_addr_rdy),
        .bus_addr_o     (bus_addr),
        .bus_data_vld_i (bus_data_vld),
        .bus_data_i     (bus_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive, sample on the falling edge, score, then advance past the rising edge.
    task automatic cycle(input logic [2:0] vld, input logic rdy, input logic dvld,
                         input logic [15:0] data, input logic exp_bvld, input int exp_gnt,
                         input string tag);
        logic [2:0] exp_rdy;
        logic [1:0] t;
        req_vld      = vld;
        bus_addr_rdy = rdy;
        bus_data_vld = dvld;
        bus_data     = data;
        @(negedge clk);
        exp_rdy = (exp_bvld && rdy) ? (3'b001 << exp_gnt) : 3'b000;
        check_eq({tag, ":bvld"}, 32'(bus_addr_vld), 32'(exp_bvld));
        check_eq({tag, ":rdy"}, 32'(req_rdy), 32'(exp_rdy));
        if (exp_bvld) check_eq({tag, ":addr"}, 32'(bus_addr), 32'(addr_tb[exp_gnt]));
        if (dvld && exp_tag_q.size() > 0) begin
            t = exp_tag_q.pop_front();
            check_eq({tag, ":rsp_vld"}, 32'(rsp_vld), 32'(3'b001 << t));
            check_eq({tag, ":rsp_data"}, 32'(rsp_data), 32'(data));
        end else begin
            check_eq({tag, ":rsp_idle"}, 32'(rsp_vld), 32'(0));
        end
        if (exp_rdy != 3'b000) exp_tag_q.push_back(2'(exp_gnt));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst_n        = 1'b0;
        req_vld      = '0;
        bus_addr_rdy = 1'b1;
        bus_data_vld = 1'b0;
        exp_tag_q.delete();
        @(negedge clk);
        check_eq({tag, ":rdy"}, 32'(req_rdy), 32'(0));
        check_eq({tag, ":rsp_vld"}, 32'(rsp_vld), 32'(0));
        check_eq({tag, ":bvld"}, 32'(bus_addr_vld), 32'(0));
        check_eq({tag, ":baddr"}, 32'(bus_addr), 32'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_g;
        addr_tb[0] = 18'h3ffff;
        addr_tb[1] = 18'h2aaaa;
        addr_tb[2] = 18'h15555;
        repeat (2) @(posedge clk);
        #1;
        do_reset("reset");

        // Single fetch routed back to requester 2
        addr_tb[2] = 18'h01234;
        cycle(3'b100, 1'b1, 1'b0, 16'h0000, 1'b1, 2, "single_req");
        cycle(3'b000, 1'b1, 1'b1, 16'hbeef, 1'b0, 0, "single_rsp");

        // Contention with all three requesters valid; beats returned back-to-back
        addr_tb[0] = 18'h00100;
        addr_tb[1] = 18'h00200;
        for (int k = 0; k < 6; k++) begin
`ifdef RISCBOY_PPU_BUSARB_RR_EN
            exp_g = k % 3;
`else
            exp_g = 0;
`endif
            cycle(3'b111, 1'b1, (k > 0), 16'(16'h1000 + k), 1'b1, exp_g, "contend");
        end
        do_reset("contend_rst");

        // Lock on requester 0 while downstream stalls; req1 raised mid-stall
        addr_tb[0] = 18'h00aaa;
        addr_tb[1] = 18'h00bbb;
        cycle(3'b001, 1'b0, 1'b0, 16'h0000, 1'b1, 0, "lock_c1");
        cycle(3'b011, 1'b0, 1'b0, 16'h0000, 1'b1, 0, "lock_c2");
        cycle(3'b011, 1'b0, 1'b0, 16'h0000, 1'b1, 0, "lock_c3");
        cycle(3'b011, 1'b1, 1'b0, 16'h0000, 1'b1, 0, "lock_hs");
        cycle(3'b010, 1'b1, 1'b1, 16'h5a5a, 1'b1, 1, "lock_next");
        // Lock on requester 1 must hold against higher-priority requester 0
        cycle(3'b010, 1'b0, 1'b1, 16'h6b6b, 1'b1, 1, "lockb_c1");
        cycle(3'b011, 1'b0, 1'b0, 16'h0000, 1'b1, 1, "lockb_hold");
        cycle(3'b011, 1'b1, 1'b0, 16'h0000, 1'b1, 1, "lockb_hs");
        cycle(3'b001, 1'b1, 1'b1, 16'h7c7c, 1'b1, 0, "lockb_after");
        cycle(3'b000, 1'b1, 1'b1, 16'h8d8d, 1'b0, 0, "lock_drain");

        // Fill the tag FIFO, then check the one-cycle bubble on the first pop
        addr_tb[0] = 18'h00c00;
        for (int k = 0; k < 4; k++) cycle(3'b001, 1'b1, 1'b0, 16'h0000, 1'b1, 0, "full_fill");
        cycle(3'b001, 1'b1, 1'b0, 16'h0000, 1'b0, 0, "full_block");
        cycle(3'b001, 1'b1, 1'b1, 16'h0f00, 1'b0, 0, "full_bubble");
        cycle(3'b001, 1'b1, 1'b1, 16'h0f01, 1'b1, 0, "full_reissue");
        for (int k = 0; k < 3; k++) begin
            cycle(3'b000, 1'b1, 1'b1, 16'(16'h0f02 + k), 1'b0, 0, "full_drain");
        end

        // Ordering: tags 2,0,1 return in issue order
        addr_tb[0] = 18'h00010;
        addr_tb[1] = 18'h00020;
        addr_tb[2] = 18'h00030;
        cycle(3'b100, 1'b1, 1'b0, 16'h0000, 1'b1, 2, "ord_i2");
        cycle(3'b001, 1'b1, 1'b0, 16'h0000, 1'b1, 0, "ord_i0");
        cycle(3'b010, 1'b1, 1'b0, 16'h0000, 1'b1, 1, "ord_i1");
        cycle(3'b000, 1'b1, 1'b1, 16'h0001, 1'b0, 0, "ord_r1");
        cycle(3'b000, 1'b1, 1'b1, 16'h0002, 1'b0, 0, "ord_r2");
        cycle(3'b000, 1'b1, 1'b1, 16'h0003, 1'b0, 0, "ord_r3");

        // Reset with three fetches outstanding; stale tags must not survive
        cycle(3'b001, 1'b1, 1'b0, 16'h0000, 1'b1, 0, "rst_i0");
        cycle(3'b010, 1'b1, 1'b0, 16'h0000, 1'b1, 1, "rst_i1");
        cycle(3'b100, 1'b1, 1'b0, 16'h0000, 1'b1, 2, "rst_i2");
        do_reset("mid_rst");
        cycle(3'b010, 1'b1, 1'b0, 16'h0000, 1'b1, 1, "rst_fresh");
        cycle(3'b000, 1'b1, 1'b1, 16'hcafe, 1'b0, 0, "rst_fresh_rsp");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
